// File: rtl/line_state_pkg.sv
// Shared definitions for the line-state memory and its flush sequencer.
package line_state_pkg;

    localparam int INDEX_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        WB_WAIT = 2'd2,
        DONE    = 2'd3
    } flush_state_t;

endpackage

// File: rtl/line_state_mem_flush_sequencer.sv
// Flush sweep controller: walks every line index, requests writeback of dirty
// lines and tells the bit arrays which line to invalidate.
module flush_sequencer
    import line_state_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
) (
    input  logic               globalclock,
    input  logic               reset,
    input  logic               flushReq,
    input  logic               wbAck,
    input  logic               lineValid,
    input  logic               lineDirty,
    output logic [INDEX_W-1:0] ptr,
    output logic               clearEn,
    output logic               flushBusy,
    output logic               flushDone,
    output logic               wbReq,
    output logic [INDEX_W-1:0] wbIndex,
    output flush_state_t       state
);

    localparam logic [INDEX_W-1:0] LAST = '1;

    // Writeback handshake: wbReq/wbIndex stay stable from entry to WB_WAIT
    // until the cycle wbAck is seen high; that cycle completes the transfer
    // and wbReq drops on the next edge. wbAck in any other state is ignored.
    assign clearEn = ((state == SCAN) && !(lineValid && lineDirty)) ||
                     ((state == WB_WAIT) && wbAck);

    always_ff @(posedge globalclock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            flushBusy <= 1'b0;
            flushDone <= 1'b0;
            wbReq     <= 1'b0;
            wbIndex   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flushDone <= 1'b0;
                    if (flushReq) begin
                        state     <= SCAN;
                        ptr       <= '0;
                        flushBusy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (lineValid && lineDirty) begin
                        state   <= WB_WAIT;
                        wbReq   <= 1'b1;
                        wbIndex <= ptr;
                    end else if (ptr == LAST) begin
                        state     <= DONE;
                        flushDone <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                WB_WAIT: begin
                    if (wbAck) begin
                        wbReq   <= 1'b0;
                        wbIndex <= '0;
                        if (ptr == LAST) begin
                            state     <= DONE;
                            flushDone <= 1'b1;
                        end else begin
                            state <= SCAN;
                            ptr   <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    flushDone <= 1'b0;
                    flushBusy <= 1'b0;
                    ptr       <= '0;
                end
                default: begin
                    state     <= IDLE;
                    flushBusy <= 1'b0;
                    flushDone <= 1'b0;
                    wbReq     <= 1'b0;
                    wbIndex   <= '0;
                    ptr       <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/line_state_mem.sv
// Per-line valid/dirty storage with a single write port and a sweep-based
// flush that writes back dirty lines and invalidates everything.
module line_state_mem
    import line_state_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
) (
    input  logic               globalclock,
    input  logic               reset,
    input  logic               wrEn,
    input  logic [INDEX_W-1:0] address,
    input  logic               inValidity,
    input  logic               inDirty,
    output logic               isValid,
    output logic               isDirty,
    input  logic               flushReq,
    output logic               flushBusy,
    output logic               flushDone,
    output logic               wbReq,
    output logic [INDEX_W-1:0] wbIndex,
    input  logic               wbAck,
    output flush_state_t       flushState
);

    localparam int N = 1 << INDEX_W;

    logic [N-1:0]       validBits;
    logic [N-1:0]       dirtyBits;
    logic [INDEX_W-1:0] ptr;
    logic               clearEn;

    assign isValid = validBits[address];
    assign isDirty = dirtyBits[address];

    flush_sequencer #(.INDEX_W(INDEX_W)) u_seq (
        .globalclock(globalclock),
        .reset      (reset),
        .flushReq   (flushReq),
        .wbAck      (wbAck),
        .lineValid  (validBits[ptr]),
        .lineDirty  (dirtyBits[ptr]),
        .ptr        (ptr),
        .clearEn    (clearEn),
        .flushBusy  (flushBusy),
        .flushDone  (flushDone),
        .wbReq      (wbReq),
        .wbIndex    (wbIndex),
        .state      (flushState)
    );

    // Writes are blocked while flushing, so a write and a sweep clear never
    // target the array in the same cycle.
    always_ff @(posedge globalclock) begin
        if (reset) begin
            validBits <= '0;
            dirtyBits <= '0;
        end else begin
            if (wrEn && !flushBusy) begin
                validBits[address] <= inValidity;
                dirtyBits[address] <= inDirty & inValidity;
            end
            if (clearEn) begin
                validBits[ptr] <= 1'b0;
                dirtyBits[ptr] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_state_mem.sv
// Randomized self-checking bench for line_state_mem with a line-array model.
module tb_line_state_mem;
    import line_state_pkg::*;

    localparam int W = 3;
    localparam int N = 8;

    logic         globalclock = 1'b0;
    logic         reset, wrEn, inValidity, inDirty, flushReq, wbAck;
    logic [W-1:0] address;
    logic         isValid, isDirty, flushBusy, flushDone, wbReq;
    logic [W-1:0] wbIndex;
    flush_state_t flushState;

    bit           exp_valid[N];
    bit           exp_dirty[N];
    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    line_state_mem #(.INDEX_W(W)) dut (
        .globalclock(globalclock), .reset(reset), .wrEn(wrEn), .address(address),
        .inValidity(inValidity), .inDirty(inDirty), .isValid(isValid), .isDirty(isDirty),
        .flushReq(flushReq), .flushBusy(flushBusy), .flushDone(flushDone),
        .wbReq(wbReq), .wbIndex(wbIndex), .wbAck(wbAck), .flushState(flushState)
    );

    // clock / reset
    always #5 globalclock = ~globalclock;

    task automatic step();
        @(posedge globalclock);
        #1;
    endtask

    // driver tasks
    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            exp_valid[i] = 1'b0;
            exp_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_write(input int a, input bit v, input bit d);
        wrEn = 1'b1; address = W'(a); inValidity = v; inDirty = d;
        step();
        wrEn = 1'b0;
        exp_valid[a] = v;
        exp_dirty[a] = v & d;
    endtask

    task automatic check_line(input int a, input string tag);
        address = W'(a);
        #1;
        vectors++;
        if (isValid !== exp_valid[a] || isDirty !== exp_dirty[a]) begin
            miscompares++;
            $display("FAIL %s line %0d: got v=%b d=%b exp v=%b d=%b", tag, a,
                     isValid, isDirty, exp_valid[a], exp_dirty[a]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < N; a++) check_line(a, tag);
    endtask

    task automatic check_quiet(input string tag);
        vectors++;
        if (flushBusy !== 1'b0 || flushDone !== 1'b0 || wbReq !== 1'b0 || wbIndex !== '0) begin
            miscompares++;
            $display("FAIL %s: got busy=%b done=%b wbReq=%b wbIndex=%0d exp all 0",
                     tag, flushBusy, flushDone, wbReq, wbIndex);
        end
    endtask

    // Runs one flush and scores it. ack_delay<0 picks a random delay per line
    // and also toggles wbAck randomly while no writeback is pending.
    task automatic run_flush(input int ack_delay, input bit inject_done,
                             input bit co_write, input int waddr, input string tag);
        int delay_total = 0;
        int busy_cycles = 0;
        int done_seen = 0;
        int done_cycle = -1;
        int wait_cnt = 0;
        int cur_delay;
        bit acked;
        if (co_write) begin
            wrEn = 1'b1; address = W'(waddr); inValidity = 1'b1; inDirty = 1'b1;
        end
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        wrEn = 1'b0;
        if (co_write) begin
            exp_valid[waddr] = 1'b1;
            exp_dirty[waddr] = 1'b1;
        end
        exp_q.delete();
        for (int i = 0; i < N; i++)
            if (exp_valid[i] && exp_dirty[i]) exp_q.push_back(W'(i));
        cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;

        while (flushBusy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            wbAck = 1'b0;
            if (flushDone === 1'b1) begin
                done_seen++;
                done_cycle = busy_cycles;
                if (inject_done) begin
                    wrEn = 1'b1; address = 3'd7; inValidity = 1'b1; inDirty = 1'b1;
                    flushReq = 1'b1;
                end
            end
            if (wbReq === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s unexpected wbReq: got wbIndex=%0d exp no request", tag, wbIndex);
                end else if (wbIndex !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL %s wbIndex: got %0d exp %0d", tag, wbIndex, exp_q[0]);
                end
                if (wait_cnt == cur_delay) wbAck = 1'b1;
                else wait_cnt++;
            end else begin
                vectors++;
                if (wbIndex !== '0) begin
                    miscompares++;
                    $display("FAIL %s idle wbIndex: got %0d exp 0", tag, wbIndex);
                end
                if (ack_delay < 0) wbAck = 1'($urandom_range(0, 1));
            end
            acked = (wbReq === 1'b1) && wbAck;
            step();
            if (acked) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                delay_total += cur_delay + 1;
                cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                wait_cnt = 0;
            end
            wbAck = 1'b0; wrEn = 1'b0; flushReq = 1'b0;
        end

        vectors++;
        if (busy_cycles != N + 1 + delay_total) begin
            miscompares++;
            $display("FAIL %s busy length: got %0d exp %0d", tag, busy_cycles, N + 1 + delay_total);
        end
        vectors++;
        if (done_seen != 1 || done_cycle != busy_cycles) begin
            miscompares++;
            $display("FAIL %s flushDone: got %0d pulses at cycle %0d exp 1 at cycle %0d",
                     tag, done_seen, done_cycle, busy_cycles);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s writebacks: got %0d missing exp 0", tag, exp_q.size());
        end
        check_quiet({tag, " after"});
        if (inject_done) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check_quiet({tag, " no restart"});
            end
        end
        model_clear();
        check_all({tag, " lines"});
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_clear();
        check_quiet("reset outputs");
        check_all("reset lines");
    endtask

    task automatic test_write();
        do_write(5, 1'b1, 1'b1);
        check_line(5, "write5");
        check_line(4, "neighbor4");
    endtask

    task automatic test_invalid_write();
        do_write(2, 1'b0, 1'b1);
        check_line(2, "invalid dirty write");
    endtask

    task automatic test_clean_flush();
        do_write(5, 1'b0, 1'b0);
        do_write(0, 1'b1, 1'b0);
        do_write(3, 1'b1, 1'b0);
        run_flush(0, 1'b0, 1'b0, 0, "clean flush");
    endtask

    task automatic test_dirty_flush();
        do_write(1, 1'b1, 1'b1);
        do_write(6, 1'b1, 1'b1);
        do_write(4, 1'b1, 1'b0);
        run_flush(3, 1'b0, 1'b0, 0, "dirty flush");
    endtask

    task automatic test_flush_ignores();
        do_write(2, 1'b1, 1'b1);
        run_flush(1, 1'b1, 1'b0, 0, "ignore during flush");
    endtask

    task automatic test_write_and_flush();
        run_flush(0, 1'b0, 1'b1, 5, "write with flushReq");
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        int bad = 0;
        do_write(1, 1'b1, 1'b1);
        do_write(3, 1'b1, 1'b1);
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        while (wbReq !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        vectors++;
        if (wbReq !== 1'b1 || wbIndex !== 3'd1) begin
            miscompares++;
            $display("FAIL reset-mid wb wait: got wbReq=%b wbIndex=%0d exp 1/1", wbReq, wbIndex);
        end
        reset = 1'b1;
        wrEn = 1'b1; address = 3'd7; inValidity = 1'b1; inDirty = 1'b1;
        wbAck = 1'b1; flushReq = 1'b1;
        step();
        reset = 1'b0; wrEn = 1'b0; wbAck = 1'b0; flushReq = 1'b0;
        model_clear();
        check_quiet("reset-mid outputs");
        for (int c = 0; c < 12; c++) begin
            step();
            if (flushDone !== 1'b0 || wbReq !== 1'b0 || flushBusy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset-mid aftermath: got %0d active cycles exp 0", bad);
        end
        check_all("reset-mid lines");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 6; w++)
                do_write(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            for (int r = 0; r < 4; r++)
                check_line(int'($urandom_range(0, N - 1)), "random read");
            run_flush(-1, 1'b0, 1'b0, 0, "random flush");
        end
    endtask

    initial begin
        reset = 1'b1; wrEn = 1'b0; address = '0; inValidity = 1'b0; inDirty = 1'b0;
        flushReq = 1'b0; wbAck = 1'b0;
        model_clear();
        test_reset();
        test_write();
        test_invalid_write();
        test_clean_flush();
        test_dirty_flush();
        test_flush_ignores();
        test_write_and_flush();
        test_reset_mid();
        test_random();
        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_state_mem.md
LINE_STATE_MEM -- requirements
Module: line_state_mem

Interface
REQ-001 SHALL have parameter INDEX_W, default 10, line-index width; line count N = 2**INDEX_W.
REQ-002 SHALL have port globalclock  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wrEn  input  1  write enable for the line at address.
REQ-005 SHALL have port address  input  INDEX_W  line index for lookup and write.
REQ-006 SHALL have port inValidity  input  1  valid bit to write.
REQ-007 SHALL have port inDirty  input  1  dirty bit to write.
REQ-008 SHALL have port isValid  output  1  valid bit of line at address.
REQ-009 SHALL have port isDirty  output  1  dirty bit of line at address.
REQ-010 SHALL have port flushReq  input  1  request to write back and invalidate all lines.
REQ-011 SHALL have port flushBusy  output  1  flush in progress.
REQ-012 SHALL have port flushDone  output  1  one-cycle pulse on flush completion.
REQ-013 SHALL have port wbReq  output  1  writeback request for a dirty line.
REQ-014 SHALL have port wbIndex  output  INDEX_W  index of the line under writeback.
REQ-015 SHALL have port wbAck  input  1  writeback accepted by downstream.

Function
REQ-016 SHALL hold N valid bits and N dirty bits; isValid/isDirty combinational from address, no latency.
REQ-017 SHALL, on wrEn with flushBusy=0, store valid<=inValidity and dirty<=inDirty&inValidity at address, visible next cycle.
REQ-018 SHALL ignore wrEn while flushBusy=1.
REQ-019 SHALL implement flush FSM with states IDLE, SCAN, WB_WAIT, DONE.
REQ-020 SHALL move IDLE->SCAN with pointer ptr=0 when flushReq=1 in IDLE; flushReq ignored in all other states.
REQ-021 SHALL, in SCAN, examine line ptr each cycle: if valid&dirty -> WB_WAIT; else clear valid and dirty of line ptr and advance ptr (or go DONE if ptr=N-1).
REQ-022 SHALL drive wbReq=1 and wbIndex=ptr exactly while in WB_WAIT; wbIndex=0 and wbReq=0 otherwise.
REQ-023 SHALL, in WB_WAIT, hold wbReq until wbAck=1 (ack accepted on any WB_WAIT cycle, including the first); on ack clear valid and dirty of line ptr, then SCAN at ptr+1, or DONE if ptr=N-1.
REQ-024 SHALL ignore wbAck outside WB_WAIT.
REQ-025 SHALL assert flushDone=1 for exactly the one DONE cycle, then return to IDLE.
REQ-026 SHALL assert flushBusy=1 in SCAN, WB_WAIT and DONE; 0 in IDLE.
REQ-027 SHALL, for a fully clean cache, hold flushBusy for exactly N+1 cycles (N SCAN + 1 DONE).
REQ-028 SHALL, on simultaneous wrEn and flushReq in IDLE, perform the write, then start the flush next cycle (written line is included in the sweep).
REQ-029 SHALL keep ptr INDEX_W bits wide; no wrap past N-1 (last line terminates sweep).

Reset
REQ-030 SHALL, on reset=1, clear all valid and dirty bits in one cycle, set FSM to IDLE, ptr=0.
REQ-031 SHALL drive after reset: isValid=0, isDirty=0, flushBusy=0, flushDone=0, wbReq=0, wbIndex=0.
REQ-032 SHALL abort any flush on reset mid-operation with no flushDone pulse and no further wbReq; reset overrides wrEn, flushReq and wbAck.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE, SCAN, WB_WAIT, DONE) and default INDEX_W in a shared package line_state_pkg.
REQ-034 SHALL implement the FSM and ptr in one sub-module flush_sequencer; the bit arrays and write port stay in line_state_mem.

Verification (INDEX_W=3, N=8)
REQ-035 SHALL cover: reset, then write addr 5 valid=1 dirty=1 -> next cycle addr 5 reads isValid=1 isDirty=1; addr 4 reads 0/0.
REQ-036 SHALL cover: write addr 2 inValidity=0 inDirty=1 -> isValid=0 isDirty=0.
REQ-037 SHALL cover: clean cache with lines 0,3 valid, flushReq pulse -> flushBusy high 9 cycles, flushDone one pulse on 9th, wbReq never high, all lines invalid after.
REQ-038 SHALL cover: lines 1 and 6 valid+dirty, flush, wbAck delayed 3 cycles each -> wbReq/wbIndex=1 then wbReq/wbIndex=6, each held until ack; flushDone once; lines 1,6 read 0/0.
REQ-039 SHALL cover: wrEn to addr 7 during flush -> ignored; flushReq during flush -> no restart.
REQ-040 SHALL cover: reset asserted while in WB_WAIT on line 1 -> next cycle wbReq=0, flushBusy=0, all bits 0, no flushDone.
